// File: rtl/mem_16x32_ctrl.sv
// Command-side controller for a 16x32 synchronous memory: command FIFO, strobe FSM, read response port.
// Optional write-verify readback is compiled in with MEM_CTRL_WRVERIFY_EN.
module mem_16x32_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_rst_n,
  output logic              mem_en,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_valid_out,
  output logic              busy,
  output logic              proto_err,
  output logic              wr_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = 1 + ADDR_W + DATA_W;

`ifdef MEM_CTRL_WRVERIFY_EN
  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, RESP, VRD, VCMP} state_t;
`else
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
`endif

  state_t              state_q, state_d;
  logic [ENT_W-1:0]    fifo_q [FIFO_DEPTH];
  logic [ENT_W-1:0]    fifo_d [FIFO_DEPTH];
  logic [PTR_W:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                mem_en_q, mem_en_d, mem_re_q, mem_re_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d, rsp_addr_q, rsp_addr_d;
  logic [DATA_W-1:0]   mem_data_in_q, mem_data_in_d, rsp_rdata_q, rsp_rdata_d;
  logic                proto_err_q, proto_err_d;
  logic                empty, full, push, pop;
  logic [ENT_W-1:0]    head;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign push  = cmd_valid && !full;
  assign head  = fifo_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q[PTR_W-1:0]] = {cmd_we, cmd_addr, cmd_wdata};
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
  end

`ifdef MEM_CTRL_WRVERIFY_EN
  logic wr_err_q, wr_err_d;
  assign wr_err = wr_err_q;
`else
  assign wr_err = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    pop           = 1'b0;
    mem_en_d      = 1'b0;
    mem_re_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_data_in_d = mem_data_in_q;
    rsp_addr_d    = rsp_addr_q;
    rsp_rdata_d   = rsp_rdata_q;
    proto_err_d   = proto_err_q;
`ifdef MEM_CTRL_WRVERIFY_EN
    wr_err_d      = wr_err_q;
`endif
    case (state_q)
      IDLE: if (!empty) pop = 1'b1;
      ISSUE: begin
        if (mem_en_q) begin
`ifdef MEM_CTRL_WRVERIFY_EN
          mem_re_d = 1'b1;
          state_d  = VRD;
`else
          if (!empty) pop = 1'b1;
          else        state_d = IDLE;
`endif
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        rsp_addr_d  = mem_addr_q;
        rsp_rdata_d = mem_data_out;
        if (!mem_valid_out) proto_err_d = 1'b1;
        state_d = RESP;
      end
      RESP: if (rsp_ready) state_d = IDLE;
`ifdef MEM_CTRL_WRVERIFY_EN
      VRD: state_d = VCMP;
      // VCMP doubles as the idle slot so a write stream runs at one per three cycles.
      VCMP: begin
        if (mem_data_out != mem_data_in_q) wr_err_d = 1'b1;
        if (!empty) pop = 1'b1;
        else        state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
    if (pop) begin
      mem_en_d      = head[ENT_W-1];
      mem_re_d      = !head[ENT_W-1];
      mem_addr_d    = head[DATA_W +: ADDR_W];
      mem_data_in_d = head[DATA_W-1:0];
      state_d       = ISSUE;
    end
  end

  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      mem_en_q      <= 1'b0;
      mem_re_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
      rsp_addr_q    <= '0;
      rsp_rdata_q   <= '0;
      proto_err_q   <= 1'b0;
`ifdef MEM_CTRL_WRVERIFY_EN
      wr_err_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      mem_en_q      <= mem_en_d;
      mem_re_q      <= mem_re_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_in_q <= mem_data_in_d;
      rsp_addr_q    <= rsp_addr_d;
      rsp_rdata_q   <= rsp_rdata_d;
      proto_err_q   <= proto_err_d;
`ifdef MEM_CTRL_WRVERIFY_EN
      wr_err_q      <= wr_err_d;
`endif
    end
  end

  assign cmd_ready   = !full;
  assign rsp_valid   = (state_q == RESP);
  assign rsp_addr    = rsp_addr_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign mem_rst_n   = ~rst;
  assign mem_en      = mem_en_q;
  assign mem_re      = mem_re_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data_in = mem_data_in_q;
  assign busy        = (state_q != IDLE) || !empty;
  assign proto_err   = proto_err_q;

endmodule
